fpu_round_pipe: RTL

//  2-stage pipelined FP32 rounding stage. Takes the normalized 24-bit mantissa plus guard/round/sticky

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_round_decide.sv | 36 +++
 rtl/fpu_round_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 constants, rounding-mode codes and pipeline payload types for the rounding stage.
package fpu_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(255);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              inc;
    logic              inexact;
    logic [2:0]        rm;
    logic              special;
  } rnd_s1_t;

  typedef struct packed {
    logic              sign;
    logic [MANT_W:0]   rnd;
    logic [EXP_W-1:0]  exp;
    logic [2:0]        rm;
    logic              inexact;
    logic              ovf;
  } rnd_s2_t;

endpackage

// File: rtl/fpu_round_decide.sv
// Combinational IEEE-754 round-increment decision from sign, LSB, guard/round/sticky and mode.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic [2:0] rm,
  input  logic       special,
  output logic       inc_c,
  output logic       inexact_c
);

  logic g, r, s, any_c;

  always_comb begin
    g         = grs[2];
    r         = grs[1];
    s         = grs[0];
    any_c     = g | r | s;
    inc_c     = 1'b0;
    inexact_c = any_c & ~special;
    // Unused mode codes fall back to round-to-nearest-even.
    case (rm)
      RM_RTZ:  inc_c = 1'b0;
      RM_RDN:  inc_c = sign & any_c;
      RM_RUP:  inc_c = ~sign & any_c;
      RM_RMM:  inc_c = g;
      default: inc_c = g & (r | s | lsb);
    endcase
    if (special) begin
      inc_c = 1'b0;
    end
  end

endmodule

// File: rtl/fpu_round_pipe.sv
// Two-stage valid/ready rounding pipeline: S1 decides the increment, S2 forms the rounded sum and exponent.
module fpu_round_pipe
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [2:0]        in_grs,
  input  logic [2:0]        in_rm,
  input  logic              in_special,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [MANT_W:0]   out_rnd,
  output logic [EXP_W-1:0]  out_exp,
  output logic [2:0]        out_rm,
  output logic              out_inexact,
  output logic              out_ovf
);

  logic    s1_valid_q, s1_valid_d;
  logic    s2_valid_q, s2_valid_d;
  rnd_s1_t s1_q, s1_d;
  rnd_s2_t s2_q, s2_d, res_c;

  logic              s1_adv_c, s2_adv_c;
  logic              inc_c, inexact_c;
  logic [MANT_W:0]   sum_c;
  logic [EXP_W:0]    exp_n_c;

  fpu_round_decide u_decide (
    .sign      (in_sign),
    .lsb       (in_mant[0]),
    .grs       (in_grs),
    .rm        (in_rm),
    .special   (in_special),
    .inc_c     (inc_c),
    .inexact_c (inexact_c)
  );

  // Handshake: each stage frees up when empty or when the stage after it moves.
  always_comb begin
    s2_adv_c   = ~s2_valid_q | out_ready;
    s1_adv_c   = ~s1_valid_q | s2_adv_c;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign    = in_sign;
        s1_d.exp     = in_exp;
        s1_d.mant    = in_mant;
        s1_d.inc     = inc_c;
        s1_d.inexact = inexact_c;
        s1_d.rm      = in_rm;
        s1_d.special = in_special;
      end
    end
  end

  // Rounded sum keeps the carry-out so the downstream mux can select the shifted mantissa.
  always_comb begin
    sum_c         = {1'b0, s1_q.mant} + (MANT_W+1)'(s1_q.inc);
    exp_n_c       = {1'b0, s1_q.exp} + (EXP_W+1)'(sum_c[MANT_W]);
    res_c.sign    = s1_q.sign;
    res_c.rnd     = sum_c;
    res_c.rm      = s1_q.rm;
    res_c.inexact = s1_q.inexact;
    res_c.exp     = exp_n_c[EXP_W-1:0];
    res_c.ovf     = 1'b0;
    if (s1_q.special) begin
      res_c.exp = s1_q.exp;
    end else if (exp_n_c >= (EXP_W+1)'(EXP_MAX)) begin
      res_c.exp = EXP_MAX;
      res_c.ovf = 1'b1;
    end
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_d = res_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign in_ready    = s1_adv_c;
  assign out_valid   = s2_valid_q;
  assign out_sign    = s2_q.sign;
  assign out_rnd     = s2_q.rnd;
  assign out_exp     = s2_q.exp;
  assign out_rm      = s2_q.rm;
  assign out_inexact = s2_q.inexact;
  assign out_ovf     = s2_q.ovf;

endmodule
